// File: rtl/aes_req_arbiter.sv
// Two-requester round-robin front end for one byte-serial AES core.
// Streams key/plaintext in, collects ciphertext, watchdogs the core.
module aes_req_arbiter #(
  parameter int TIMEOUT = 256,
  parameter int TO_W    = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic [127:0] key0,
  input  logic [127:0] pt0,
  input  logic         req1,
  input  logic [127:0] key1,
  input  logic [127:0] pt1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic [127:0] ct_out,
  output logic         err,
  output logic         aes_enable,
  output logic [7:0]   aes_key_byte,
  output logic [7:0]   aes_state_byte,
  input  logic         aes_ready,
  input  logic [7:0]   aes_state_out_byte,
  input  logic         aes_load
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    LOAD,
    WAIT,
    SKIP,
    UNLOAD,
    DONE
  } state_t;

  state_t            state;
  logic [127:0]      keyL;
  logic [127:0]      ptL;
  logic [3:0]        bc;
  logic [TO_W-1:0]   wdog;
  logic              rrLast;
  logic              pick1;
  logic [6:0]        ctLsb;
  logic              unusedLoad;

  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

  // core load flag is observed by external monitors only
  assign unusedLoad = aes_load;

  // byte bc lands at [127-8*bc -: 8]; 15-bc is ~bc
  assign ctLsb = {~bc, 3'b000};

  // requester 1 wins when alone, or on a tie when 0 went last
  always_comb begin
    pick1 = req1 & (~req0 | ~rrLast);
  end

  // job sequencer with registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      keyL           <= '0;
      ptL            <= '0;
      bc             <= '0;
      wdog           <= '0;
      rrLast         <= 1'b1;
      gnt0           <= 1'b0;
      gnt1           <= 1'b0;
      done0          <= 1'b0;
      done1          <= 1'b0;
      err            <= 1'b0;
      ct_out         <= '0;
      aes_enable     <= 1'b0;
      aes_key_byte   <= '0;
      aes_state_byte <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req0 | req1) begin
            err        <= 1'b0;
            aes_enable <= 1'b1;
            state      <= START;
            if (pick1) begin
              gnt1   <= 1'b1;
              keyL   <= key1;
              ptL    <= pt1;
              rrLast <= 1'b1;
            end else begin
              gnt0   <= 1'b1;
              keyL   <= key0;
              ptL    <= pt0;
              rrLast <= 1'b0;
            end
          end
        end
        START: begin
          aes_key_byte   <= keyL[127:120];
          aes_state_byte <= ptL[127:120];
          keyL           <= {keyL[119:0], 8'h00};
          ptL            <= {ptL[119:0], 8'h00};
          bc             <= '0;
          state          <= LOAD;
        end
        LOAD: begin
          if (bc == 4'd15) begin
            aes_key_byte   <= '0;
            aes_state_byte <= '0;
            wdog           <= '0;
            state          <= WAIT;
          end else begin
            aes_key_byte   <= keyL[127:120];
            aes_state_byte <= ptL[127:120];
            keyL           <= {keyL[119:0], 8'h00};
            ptL            <= {ptL[119:0], 8'h00};
            bc             <= bc + 4'd1;
          end
        end
        WAIT: begin
          if (aes_ready) begin
            state <= SKIP;
          end else if (wdog == WD_LAST) begin
            err        <= 1'b1;
            aes_enable <= 1'b0;
            done0      <= gnt0;
            done1      <= gnt1;
            state      <= DONE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        SKIP: begin
          bc    <= '0;
          state <= UNLOAD;
        end
        UNLOAD: begin
          if (aes_ready) begin
            ct_out[ctLsb +: 8] <= aes_state_out_byte;
            bc                 <= bc + 4'd1;
            if (bc == 4'd15) begin
              aes_enable <= 1'b0;
              done0      <= gnt0;
              done1      <= gnt1;
              state      <= DONE;
            end
          end else begin
            err        <= 1'b1;
            aes_enable <= 1'b0;
            done0      <= gnt0;
            done1      <= gnt1;
            state      <= DONE;
          end
        end
        DONE: begin
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Bench for aes_req_arbiter: byte-serial core model plus
// a done-driven scoreboard fed by directed jobs.
module tb_aes_req_arbiter;

  localparam int TO  = 32;
  localparam int LAT = 5;
  localparam int RS  = 17 + LAT;

  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] ALL = '1;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req0 = 1'b0;
  logic         req1 = 1'b0;
  logic [127:0] key0 = '0;
  logic [127:0] pt0 = '0;
  logic [127:0] key1 = '0;
  logic [127:0] pt1 = '0;
  logic         gnt0, gnt1, done0, done1, err;
  logic [127:0] ct_out;
  logic         aes_enable;
  logic [7:0]   aes_key_byte, aes_state_byte;
  logic         aes_ready = 1'b0;
  logic [7:0]   aes_state_out_byte = '0;
  logic         aes_load = 1'b0;

  aes_req_arbiter #(.TIMEOUT(TO), .TO_W(6)) dut (
    .clk(clk),
    .reset(reset),
    .req0(req0),
    .key0(key0),
    .pt0(pt0),
    .req1(req1),
    .key1(key1),
    .pt1(pt1),
    .gnt0(gnt0),
    .gnt1(gnt1),
    .done0(done0),
    .done1(done1),
    .ct_out(ct_out),
    .err(err),
    .aes_enable(aes_enable),
    .aes_key_byte(aes_key_byte),
    .aes_state_byte(aes_state_byte),
    .aes_ready(aes_ready),
    .aes_state_out_byte(aes_state_out_byte),
    .aes_load(aes_load)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  function automatic void chk(string name, logic [127:0] act,
                              logic [127:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h want %h", name, act, req);
  endfunction

  // known vectors; anything else gets a cheap mix so bad streaming shows
  function automatic logic [127:0] aesRef(logic [127:0] k,
                                          logic [127:0] p);
    if (k == K0 && p == P0) return C0;
    if (k == K1 && p == P1) return C1;
    return k ^ p ^ {16{8'h5a}};
  endfunction

  // core model: enable cycle 0 idle, 1..16 sample bytes, then after LAT
  // ready rises; two junk bytes lead the 16 ciphertext bytes
  int           mode = 0;
  int           mCnt = 0;
  int           mIdx;
  logic [127:0] mKey, mPt, mCt;

  always @(posedge clk) begin
    if (!aes_enable) begin
      mCnt = 0;
      aes_ready <= 1'b0;
      aes_state_out_byte <= '0;
      aes_load <= 1'b0;
    end else begin
      if (mCnt >= 1 && mCnt <= 16) begin
        mKey[127-8*(mCnt-1) -: 8] = aes_key_byte;
        mPt[127-8*(mCnt-1) -: 8] = aes_state_byte;
      end
      mCnt = mCnt + 1;
      aes_load <= (mCnt >= 1 && mCnt <= 16);
      mCt = aesRef(mKey, mPt);
      mIdx = mCnt - RS;
      if (mode != 1 && mIdx >= 0 && mIdx < (mode == 2 ? 12 : 18)) begin
        aes_ready <= 1'b1;
        aes_state_out_byte <= (mIdx < 2) ? 8'hee
                              : mCt[127-8*(mIdx-2) -: 8];
      end else begin
        aes_ready <= 1'b0;
        aes_state_out_byte <= '0;
      end
    end
  end

  typedef struct {
    logic         id;
    logic         err;
    logic [127:0] ct;
    logic [127:0] mask;
    int           run;
  } exp_t;

  exp_t sb[$];

  task automatic push(logic id, logic e, logic [127:0] ct,
                      logic [127:0] mask, int run);
    exp_t x;
    x.id = id;
    x.err = e;
    x.ct = ct;
    x.mask = mask;
    x.run = run;
    sb.push_back(x);
  endtask

  // monitor: enable run/gap tracking and scoreboard pops on done
  int   enRun = 0;
  int   lowRun = 0;
  bit   prevEn = 1'b0;
  bit   seenJob = 1'b0;
  exp_t e;

  always @(negedge clk) begin
    if (!reset) begin
      prevEn = 1'b0;
      seenJob = 1'b0;
      lowRun = 0;
    end else begin
      if (aes_enable) begin
        if (!prevEn) begin
          if (seenJob) chk("en_gap", lowRun >= 2, 1);
          enRun = 0;
        end
        enRun++;
      end else begin
        if (prevEn) lowRun = 0;
        lowRun++;
      end
      prevEn = aes_enable;
      if (done0 | done1) begin
        chk("gnt_excl", gnt0 & gnt1, 0);
        chk("done_excl", done0 & done1, 0);
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done: done0=%b done1=%b", done0, done1);
        end else begin
          e = sb.pop_front();
          chk("done_id", done1, e.id);
          chk("gnt_owner", e.id ? gnt1 : gnt0, 1);
          chk("err", err, e.err);
          chk("en_in_done", aes_enable, 0);
          if (e.mask != '0) chk("ct", ct_out & e.mask, e.ct & e.mask);
          if (e.run != 0) chk("en_run", enRun, e.run);
        end
        seenJob = 1'b1;
      end
    end
  end

  task automatic runJob(logic id, logic [127:0] k, logic [127:0] p);
    bit seen;
    @(negedge clk);
    if (id) begin
      key1 = k;
      pt1 = p;
      req1 = 1'b1;
    end else begin
      key0 = k;
      pt0 = p;
      req0 = 1'b1;
    end
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (id ? done1 : done0) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      $display("FAIL job_timeout: requester %0d got no done", id);
    end
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int  nd;
    bit  seen;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {gnt0, gnt1, done0, done1, err, aes_enable,
                    aes_key_byte, aes_state_byte}, 0);
    chk("rst_ct", ct_out, 0);
    reset = 1'b1;

    push(0, 0, C0, ALL, 40);
    runJob(0, K0, P0);
    push(1, 0, C1, ALL, 40);
    runJob(1, K1, P1);

    // both held: rr_last is 1 again, so 0 wins first
    push(0, 0, C0, ALL, 40);
    push(1, 0, C1, ALL, 40);
    push(0, 0, C0, ALL, 40);
    push(1, 0, C1, ALL, 40);
    @(negedge clk);
    key0 = K0; pt0 = P0; key1 = K1; pt1 = P1;
    req0 = 1'b1;
    req1 = 1'b1;
    nd = 0;
    for (int i = 0; i < 1000 && nd < 4; i++) begin
      @(negedge clk);
      if (done0 | done1) nd++;
    end
    if (nd < 4) begin
      checks++;
      $display("FAIL both_timeout: got %0d dones want 4", nd);
    end
    req0 = 1'b0;
    req1 = 1'b0;

    // watchdog: 32 WAIT cycles, then a normal job
    mode = 1;
    push(0, 1, '0, '0, 1 + 16 + TO);
    runJob(0, K0, P0);
    mode = 0;
    push(0, 0, C0, ALL, 40);
    runJob(0, K0, P0);

    // reset during LOAD byte 7
    @(negedge clk);
    key0 = K1;
    pt0 = P1;
    req0 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (gnt0) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      $display("FAIL gnt_timeout: no gnt0 for reset job");
    end
    repeat (8) @(negedge clk);
    chk("load_b7", aes_key_byte, K1[71:64]);
    reset = 1'b0;
    #1;
    chk("rst_mid_ctl", {gnt0, gnt1, done0, done1, err, aes_enable,
                        aes_key_byte, aes_state_byte}, 0);
    chk("rst_mid_ct", ct_out, 0);
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rel_en", aes_enable, 0);
    push(0, 0, C0, ALL, 40);
    runJob(0, K0, P0);

    // ready drops after 10 bytes; low 6 bytes keep the previous result
    mode = 2;
    push(1, 1, {C1[127:48], C0[47:0]}, ALL, 35);
    runJob(1, K1, P1);
    mode = 0;

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
